temporal_decoder: RTL and testbench
===================================

Name: temporal_decoder

Overview:
- Downstream consumer of the race-logic primitives (equal, min/max, inhibit).
- Converts one temporal-coded wire into a binary arrival time, measured in clock cycles from the start of a gamma cycle.
- Presents the result on a valid/ready output for the digital back end (accumulators, readout).
- An input that never arrives within the gamma cycle decodes to "infinity", which is all-ones.

Parameters:
- GAMMA_CYCLE_WIDTH, 16: width of the time counter and of dout. INF = 2^GAMMA_CYCLE_WIDTH - 1.
- PULSE_WIDTH, 8: cycles edge_in must be inactive after gamma_start before the decoder arms. Models the reset pulse of upstream sr_latch stages. 0 means arm immediately.

Ports:
- clk, input, 1: single clock; all logic rising-edge.
- rst_n, input, 1: asynchronous active-low reset.
- gamma_start, input, 1: one-cycle pulse that begins a gamma cycle (time 0).
- edge_in, input, 1: temporal-coded signal. Monotone within a gamma cycle; its active level marks arrival.
- dout, output, GAMMA_CYCLE_WIDTH: decoded arrival time.
- dout_valid, output, 1: dout holds an unconsumed result.
- dout_ready, input, 1: consumer accepts dout when dout_valid & dout_ready.
- timeout, output, 1: qualifies dout. 1 means no edge was seen (dout == INF).
- overrun, output, 1: sticky. Set when a result is dropped because the output was occupied. Cleared only by rst_n.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; counter = 0.
  - dout = 0, dout_valid = 0, timeout = 0, overrun = 0.
- Clock-domain handling: edge_in is synchronous to clk; no synchronizer inside the block. "active" = edge_in high (default build).
- Elapsed time: t = 0 in the cycle gamma_start is sampled high; t increments by 1 per cycle after that. The internal counter saturates at INF.
- FSM:
  - IDLE: wait for gamma_start, then go to BLANK (PULSE_WIDTH > 0) or ARMED (PULSE_WIDTH = 0).
  - BLANK: edge_in is ignored for cycles t = 0 .. PULSE_WIDTH-1, then go to ARMED.
  - ARMED: on the first cycle with edge_in active, capture t and go to IDLE. If t reaches INF, capture INF with timeout = 1 and go to IDLE.
- PULSE_WIDTH = 0 and edge_in active in the gamma_start cycle: capture 0.
- gamma_start while in BLANK or ARMED: the current cycle ends with no arrival. Capture INF with timeout = 1 in that cycle, and restart at t = 0 in the same cycle (back-to-back gamma cycles need no idle gap).
- Capture → output:
  - Registered: dout, timeout and dout_valid update on the clock edge ending the capture cycle (latency 1).
  - If dout_valid is set and a handshake occurs in the same cycle as a new capture, the new result loads and dout_valid stays 1.
  - If dout_valid is set with no handshake, the new result is dropped, overrun <= 1, and dout is unchanged.
- Handshake: dout_valid clears on the cycle after a handshake, unless a new result loads in the same cycle.
- While dout_valid is set, dout and timeout are stable; the bench asserts this.
- Counter width rule: no wrap. An arrival at t = INF is indistinguishable from a timeout, and is reported with timeout = 1.
- rst_n asserted mid-cycle aborts everything: no partial result, overrun cleared.

Optional Feature:
- Macro: TEMPORAL_DECODER_FALLING_EN.
- Defined: falling-edge encoding. Edge_in idles high; "active" = edge_in low. This matches the falling-transition primitives.
- Undefined: rising-edge encoding; "active" = edge_in high.
- All timing, blanking and handshake behaviour is identical in both builds; only the active level is inverted.

Test Plan:
1. PULSE_WIDTH = 8, gamma_start at cycle 0, edge_in rises at cycle 20, dout_ready = 1 → dout = 20, timeout = 0, dout_valid high exactly cycle 21.
2. PULSE_WIDTH = 8, edge_in already active at cycle 3, stays active → ignored in BLANK; captured at first ARMED cycle → dout = 8.
3. GAMMA_CYCLE_WIDTH = 4, no edge → dout = 15, timeout = 1 at cycle 16. A second gamma_start at cycle 10 instead → dout = 15, timeout = 1 at cycle 11; the new cycle times from 0.
4. dout_ready held 0, two gamma cycles each with an edge at t = 12 → first dout = 12 held stable, second dropped, overrun = 1. Raise dout_ready → single handshake, dout_valid = 0 next cycle.
5. Capture coinciding with handshake of a prior result → dout_valid stays 1, dout takes the new value, overrun stays 0.
6. rst_n pulsed low asynchronously mid-ARMED, and the falling-build regression of scenario 1 (edge_in falls at cycle 20) → all outputs 0 immediately on reset; falling build gives dout = 20.

Source files
------------

// File: rtl/temporal_decoder.sv
// temporal_decoder
// Converts one temporal-coded wire into a binary arrival time measured in
// clock cycles from the start of a gamma cycle. The result is presented on a
// valid/ready output. A missing arrival decodes to INF (all ones) with
// timeout = 1.
//
// Optional build macro: TEMPORAL_DECODER_FALLING_EN
//   undefined : rising-edge encoding, edge_in high marks arrival
//   defined   : falling-edge encoding, edge_in idles high, low marks arrival
//
// Output handshake: dout_valid is held high with dout/timeout stable until a
// cycle where dout_valid & dout_ready are both high. That cycle transfers the
// result, and dout_valid drops on the next edge unless a new result loads on
// the same edge. dout_valid never depends combinationally on dout_ready.
//
// FSM state is exposed on the internal signal `state` for checker binding.

module temporal_decoder #(
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int PULSE_WIDTH       = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         gamma_start,
  input  logic                         edge_in,
  output logic [GAMMA_CYCLE_WIDTH-1:0] dout,
  output logic                         dout_valid,
  input  logic                         dout_ready,
  output logic                         timeout,
  output logic                         overrun
);

  localparam int W = GAMMA_CYCLE_WIDTH;

  // Saturation value of the time counter; also the "no arrival" code.
  localparam logic [W-1:0] INF = '1;

  // Last blanked value of t. Only used when PULSE_WIDTH >= 2, because t = 0
  // is already spent in IDLE on the gamma_start cycle.
  localparam logic [W-1:0] BLANK_LAST = W'(PULSE_WIDTH - 1);

  // With PULSE_WIDTH of 0 or 1 the blanking window is at most the
  // gamma_start cycle itself, so the decoder goes straight to ARMED.
  localparam bit SKIP_BLANK = (PULSE_WIDTH <= 1);

  // Value of t loaded for the cycle after gamma_start.
  localparam logic [W-1:0] T_ONE = W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    ARMED = 2'd2
  } state_t;

  state_t       state;
  logic [W-1:0] cnt;       // elapsed time t of the current cycle (BLANK/ARMED)
  logic [W-1:0] cnt_inc;   // saturating increment of cnt
  logic         active;    // edge_in is at its arrival level

  logic         cap_fire;  // a result is produced in this cycle
  logic [W-1:0] cap_time;  // captured arrival time
  logic         cap_to;    // captured result is a timeout

`ifdef TEMPORAL_DECODER_FALLING_EN
  // Falling-edge encoding: the wire idles high and falls on arrival.
  assign active = ~edge_in;
`else
  // Rising-edge encoding: the wire idles low and rises on arrival.
  assign active = edge_in;
`endif

  // Counter never wraps; it parks at INF.
  assign cnt_inc = (cnt == INF) ? INF : cnt + T_ONE;

  // Decide whether this cycle produces a result and what that result is.
  always_comb begin
    cap_fire = 1'b0;
    cap_time = '0;
    cap_to   = 1'b0;
    unique case (state)
      IDLE: begin
        // Zero-length blanking: an arrival already present at t = 0 counts.
        if (gamma_start && (PULSE_WIDTH == 0) && active) begin
          cap_fire = 1'b1;
          cap_time = '0;
        end
      end
      BLANK: begin
        // A new gamma cycle ends the current one without an arrival.
        if (gamma_start) begin
          cap_fire = 1'b1;
          cap_time = INF;
          cap_to   = 1'b1;
        end
      end
      ARMED: begin
        if (gamma_start) begin
          cap_fire = 1'b1;
          cap_time = INF;
          cap_to   = 1'b1;
        end else if (active || (cnt == INF)) begin
          // An arrival at t = INF cannot be told apart from a timeout.
          cap_fire = 1'b1;
          cap_time = cnt;
          cap_to   = (cnt == INF);
        end
      end
      default: begin
        cap_fire = 1'b0;
      end
    endcase
  end

  // Gamma-cycle sequencer: tracks t and walks IDLE -> BLANK -> ARMED -> IDLE.
  // A gamma_start in BLANK or ARMED restarts timing at t = 0 in that same
  // cycle, so back-to-back gamma cycles need no idle gap. The restart cycle
  // itself reports the timeout of the old cycle and cannot also report an
  // arrival for the new one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (gamma_start && !cap_fire) begin
            state <= SKIP_BLANK ? ARMED : BLANK;
            cnt   <= T_ONE;
          end
        end
        BLANK: begin
          if (gamma_start) begin
            state <= SKIP_BLANK ? ARMED : BLANK;
            cnt   <= T_ONE;
          end else begin
            if ((cnt == BLANK_LAST) || (cnt == INF)) begin
              state <= ARMED;
            end
            cnt <= cnt_inc;
          end
        end
        ARMED: begin
          if (gamma_start) begin
            state <= SKIP_BLANK ? ARMED : BLANK;
            cnt   <= T_ONE;
          end else if (cap_fire) begin
            state <= IDLE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Output register: load a new result when the slot is free or being
  // drained this cycle; otherwise drop it and flag overrun (sticky).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      timeout    <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (cap_fire) begin
        if (!dout_valid || dout_ready) begin
          dout       <= cap_time;
          timeout    <= cap_to;
          dout_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_temporal_decoder.sv
// tb_temporal_decoder
// Directed bench for temporal_decoder. Three instances:
//   dut   : GAMMA_CYCLE_WIDTH 16, PULSE_WIDTH 8
//   dut_z : GAMMA_CYCLE_WIDTH 16, PULSE_WIDTH 0 (shares inputs with dut)
//   dut4  : GAMMA_CYCLE_WIDTH 4,  PULSE_WIDTH 8 (own inputs)
// Build with TEMPORAL_DECODER_FALLING_EN to run the falling-edge encoding;
// the bench flips its arrival level to match.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.

module tb_temporal_decoder;

`ifdef TEMPORAL_DECODER_FALLING_EN
  localparam logic ACT = 1'b0;
`else
  localparam logic ACT = 1'b1;
`endif
  localparam logic IDL = ~ACT;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUT signals ----------------
  logic        gamma_start;
  logic        edge_in;
  logic        dout_ready;
  logic [15:0] dout;
  logic        dout_valid;
  logic        timeout;
  logic        overrun;

  logic [15:0] dout_z;
  logic        valid_z;
  logic        timeout_z;
  logic        overrun_z;

  logic        g4;
  logic        e4;
  logic        r4;
  logic [3:0]  dout4;
  logic        valid4;
  logic        to4;
  logic        ov4;

  temporal_decoder #(.GAMMA_CYCLE_WIDTH(16), .PULSE_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .gamma_start(gamma_start), .edge_in(edge_in),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .timeout(timeout), .overrun(overrun)
  );

  temporal_decoder #(.GAMMA_CYCLE_WIDTH(16), .PULSE_WIDTH(0)) dut_z (
    .clk(clk), .rst_n(rst_n), .gamma_start(gamma_start), .edge_in(edge_in),
    .dout(dout_z), .dout_valid(valid_z), .dout_ready(dout_ready),
    .timeout(timeout_z), .overrun(overrun_z)
  );

  temporal_decoder #(.GAMMA_CYCLE_WIDTH(4), .PULSE_WIDTH(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .gamma_start(g4), .edge_in(e4),
    .dout(dout4), .dout_valid(valid4), .dout_ready(r4),
    .timeout(to4), .overrun(ov4)
  );

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------- stability monitor on dut ----------------
  // A held result (valid, not accepted) must survive the edge unchanged.
  logic        hold;
  logic [15:0] held_d;
  logic        held_t;

  initial begin
    forever begin
      @(posedge clk);
      hold   = rst_n && dout_valid && !dout_ready;
      held_d = dout;
      held_t = timeout;
      #2;
      if (hold && rst_n) begin
        checks++;
        assert (dout_valid === 1'b1 && dout === held_d && timeout === held_t) else begin
          errors++;
          $error("FAIL hold_stable: observed v=%0b d=%0d t=%0b expected v=1 d=%0d t=%0b",
                 dout_valid, dout, timeout, held_d, held_t);
        end
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst_n       = 1'b0;
    gamma_start = 1'b0;
    edge_in     = IDL;
    dout_ready  = 1'b1;
    g4          = 1'b0;
    e4          = IDL;
    r4          = 1'b1;

    // Reset state
    #3;
    chk("rst_dout", 32'(dout), 0);
    chk("rst_valid", 32'(dout_valid), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_overrun", 32'(overrun), 0);
    ticks(2);
    rst_n = 1'b1;
    tick();

    // 1: edge at t = 20, result visible exactly on cycle 21
    gamma_start = 1'b1; tick();
    gamma_start = 1'b0; ticks(19);
    chk("s1_valid_early", 32'(dout_valid), 0);
    edge_in = ACT; tick();
    chk("s1_valid", 32'(dout_valid), 1);
    chk("s1_dout", 32'(dout), 20);
    chk("s1_timeout", 32'(timeout), 0);
    chk("s1_pw0_dout", 32'(dout_z), 20);
    tick();
    chk("s1_valid_drop", 32'(dout_valid), 0);
    edge_in = IDL; tick();

    // 2: edge active from t = 3; PW 8 ignores it until t = 8, PW 0 takes 3
    gamma_start = 1'b1; tick();
    gamma_start = 1'b0; ticks(2);
    edge_in = ACT; tick();
    chk("s2_pw0_valid", 32'(valid_z), 1);
    chk("s2_pw0_dout", 32'(dout_z), 3);
    chk("s2_blank_valid", 32'(dout_valid), 0);
    ticks(4);
    chk("s2_blank_valid8", 32'(dout_valid), 0);
    tick();
    chk("s2_valid", 32'(dout_valid), 1);
    chk("s2_dout", 32'(dout), 8);
    chk("s2_timeout", 32'(timeout), 0);
    edge_in = IDL; tick();

    // PW 0: edge already active in the gamma_start cycle captures 0
    edge_in = ACT; gamma_start = 1'b1; tick();
    chk("pw0_t0_valid", 32'(valid_z), 1);
    chk("pw0_t0_dout", 32'(dout_z), 0);
    chk("pw0_t0_timeout", 32'(timeout_z), 0);
    gamma_start = 1'b0; ticks(8);
    chk("pw8_t0_dout", 32'(dout), 8);
    edge_in = IDL; tick();

    // 3: width 4, no edge -> INF with timeout on cycle 16
    g4 = 1'b1; tick();
    g4 = 1'b0; ticks(14);
    chk("s3_valid_early", 32'(valid4), 0);
    tick();
    chk("s3_valid", 32'(valid4), 1);
    chk("s3_dout", 32'(dout4), 15);
    chk("s3_timeout", 32'(to4), 1);
    tick();
    chk("s3_valid_drop", 32'(valid4), 0);

    // 3b: second gamma_start at t = 10 -> INF on cycle 11, new cycle from 0
    g4 = 1'b1; tick();
    g4 = 1'b0; ticks(9);
    g4 = 1'b1; tick();
    chk("s3b_valid", 32'(valid4), 1);
    chk("s3b_dout", 32'(dout4), 15);
    chk("s3b_timeout", 32'(to4), 1);
    g4 = 1'b0; ticks(8);
    e4 = ACT; tick();
    chk("s3b_new_dout", 32'(dout4), 9);
    chk("s3b_new_timeout", 32'(to4), 0);
    e4 = IDL; tick();

    // 3c: arrival exactly at t = INF is reported as a timeout
    g4 = 1'b1; tick();
    g4 = 1'b0; ticks(14);
    e4 = ACT; tick();
    chk("s3c_dout", 32'(dout4), 15);
    chk("s3c_timeout", 32'(to4), 1);
    e4 = IDL; tick();

    // 4: consumer stalled, second result dropped, overrun sticky
    dout_ready = 1'b0;
    gamma_start = 1'b1; tick();
    gamma_start = 1'b0; ticks(11);
    edge_in = ACT; tick();
    chk("s4_dout", 32'(dout), 12);
    chk("s4_valid", 32'(dout_valid), 1);
    chk("s4_overrun0", 32'(overrun), 0);
    edge_in = IDL; ticks(6);
    gamma_start = 1'b1; tick();
    gamma_start = 1'b0; ticks(11);
    edge_in = ACT; tick();
    chk("s4_overrun", 32'(overrun), 1);
    chk("s4_dout_kept", 32'(dout), 12);
    chk("s4_timeout_kept", 32'(timeout), 0);
    chk("s4_pw0_overrun", 32'(overrun_z), 1);
    edge_in = IDL;
    dout_ready = 1'b1; tick();
    chk("s4_valid_drop", 32'(dout_valid), 0);
    chk("s4_overrun_sticky", 32'(overrun), 1);

    // 6: asynchronous reset in the middle of ARMED
    dout_ready = 1'b0;
    gamma_start = 1'b1; tick();
    gamma_start = 1'b0; ticks(9);
    edge_in = ACT; tick();
    chk("s6_pre_dout", 32'(dout), 10);
    edge_in = IDL;
    gamma_start = 1'b1; tick();
    gamma_start = 1'b0; ticks(10);
    rst_n = 1'b0;
    #1;
    chk("s6_rst_dout", 32'(dout), 0);
    chk("s6_rst_valid", 32'(dout_valid), 0);
    chk("s6_rst_timeout", 32'(timeout), 0);
    chk("s6_rst_overrun", 32'(overrun), 0);
    tick();
    rst_n = 1'b1;
    edge_in = ACT; ticks(3);
    chk("s6_no_partial", 32'(dout_valid), 0);
    edge_in = IDL; tick();

    // 5: new capture coincides with handshake of the held result
    gamma_start = 1'b1; tick();
    gamma_start = 1'b0; ticks(8);
    edge_in = ACT; tick();
    chk("s5_first_dout", 32'(dout), 9);
    edge_in = IDL;
    gamma_start = 1'b1; tick();
    gamma_start = 1'b0; ticks(10);
    edge_in = ACT; dout_ready = 1'b1; tick();
    chk("s5_valid", 32'(dout_valid), 1);
    chk("s5_dout", 32'(dout), 11);
    chk("s5_timeout", 32'(timeout), 0);
    chk("s5_overrun", 32'(overrun), 0);
    edge_in = IDL; tick();
    chk("s5_valid_drop", 32'(dout_valid), 0);

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
